pdp8_brk_arb: RTL
=================

# pdp8_brk_arb

Data-break (DMA) arbiter between the PDP-8 CPU and up to four IO device controllers (RF08 disk first, then others). It collects break requests, asks the CPU for a memory slot, grants one device per break cycle by fixed or round-robin priority, and runs that device's single-word transfer against main memory. It sits between the device controllers, the CPU major-state sequencer and the memory port.

## Interface
- RR, 0, 0 = fixed priority (device 0 highest); 1 = round-robin starting after the last winner
- TIMEOUT, 63, max XFER cycles waiting for ram_done before aborting (6-bit counter)
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- dev_req  in  4  per-device break request, level
- dev_addr  in  60  four 15-bit addresses (field[14:12], word[11:0]); device n at [15n+14:15n]
- dev_wdata  in  48  four 12-bit write words; device n at [12n+11:12n]
- dev_write  in  4  1 = write cycle, 0 = read cycle, per device
- dev_grant  out  4  one-hot, high for the whole break cycle of the winner
- dev_done  out  4  one-cycle pulse to the winner at end of cycle
- dev_err  out  1  one-cycle pulse with dev_done when the cycle timed out
- dev_rdata  out  12  read word; valid while dev_done is high
- cpu_slot  in  1  one-cycle pulse: CPU at a major-cycle boundary where a break may be inserted
- brk_req  out  1  to CPU: a break is wanted
- brk_active  out  1  to CPU: break cycle in progress, CPU must stall
- ram_addr  out  15  memory address
- ram_rd  out  1  read strobe, level
- ram_wr  out  1  write strobe, level
- ram_data_out  out  12  write data
- ram_data_in  in  12  read data, valid when ram_done high
- ram_done  in  1  memory cycle complete

## Operation
- States: IDLE, WAIT_SLOT, XFER, DONE.
- IDLE: brk_req=0. Any dev_req bit high -> WAIT_SLOT. cpu_slot ignored.
- WAIT_SLOT: brk_req=1. On cpu_slot, sample dev_req: none high -> IDLE (no grant); otherwise pick winner, latch its addr/wdata/write into internal registers, -> XFER. Requests are sampled only at cpu_slot.
- Winner selection: RR=0 lowest index wins; RR=1 first high bit searching upward from (last_winner+1) mod 4, wrapping 3->0.
- XFER: dev_grant[winner]=1, brk_active=1, ram_addr/ram_data_out from latched registers, ram_rd or ram_wr held high. Timeout counter cleared on entry, increments each XFER cycle. ram_done high -> capture ram_data_in into dev_rdata register (read cycles only), -> DONE. Counter reaching TIMEOUT without ram_done -> DONE with error flag set, dev_rdata = 12'o0000.
- DONE: dev_done[winner]=1, dev_err=error flag, dev_grant and brk_active still high this cycle, ram strobes low. Update last_winner. Next: any dev_req high -> WAIT_SLOT, else IDLE.
- Devices must drop dev_req by the next cpu_slot after their dev_done; a still-high request is treated as a new request.
- dev_addr/dev_wdata/dev_write changes after the slot do not affect the cycle in progress.

## Timing
- Reset: state IDLE, last_winner=3 (so RR starts at device 0), all outputs 0, dev_rdata=0.
- reset_n low at any point, including mid-XFER: all strobes, grants and brk_active drop asynchronously; no dev_done issued.
- dev_req rise -> brk_req high next edge (1 cycle).
- cpu_slot edge -> dev_grant, brk_active, ram strobe high at that same edge (registered, visible next cycle).
- ram_done sampled high in XFER cycle k -> dev_done high in cycle k+1; min cpu_slot-to-dev_done latency 2 cycles.
- Exactly one ram_rd or ram_wr high, never both; never high outside XFER.
- cpu_slot in XFER or DONE ignored; back-to-back breaks need a new cpu_slot each.
- ram_done outside XFER ignored.

## Test plan
- Single read: dev_req=4'b0001, addr 15'o10200, cpu_slot, ram_done 3 cycles later with data 12'o1234 -> ram_rd high 3 cycles at 15'o10200, dev_done=4'b0001 with dev_rdata=12'o1234, back to IDLE, brk_req=0.
- Fixed priority, RR=0: dev_req=4'b1010 held, three slots -> winners 1,1,1; device 3 starves while 1 requests.
- Round-robin, RR=1: dev_req=4'b1111 held, five slots -> grants 0,1,2,3,0 one-hot; write to 15'o00017 data 12'o7777 shows ram_wr and ram_data_out=12'o7777.
- Withdrawn request: dev_req pulses high then low before cpu_slot -> brk_req rises then state returns to IDLE at slot, no grant, no ram strobe.
- Timeout: TIMEOUT=63, ram_done never asserted -> after 63 XFER cycles dev_done and dev_err pulse together, dev_rdata=0, strobes drop.
- Reset mid-XFER: reset_n low 2 cycles into XFER -> ram_rd, dev_grant, brk_active drop immediately, no dev_done; after release, state IDLE and next request served normally.

Source files
------------

// File: rtl/pdp8_brk_arb_if.sv
// pdp8_brk_arb_if
//   Bundles every signal between the data-break arbiter and its environment:
//   the four device controllers, the CPU major-state sequencer and the memory
//   port. Clock and reset stay outside as plain ports.
//
//   modport slave  : the arbiter's view (takes requests, drives grants/strobes)
//   modport master : the environment's view (devices, CPU and memory)
//
//   Handshake semantics (this one comment is the reference):
//     device side : dev_req is a level request. A request is only seen when it
//                   is high at a cpu_slot pulse. The winner's dev_grant stays
//                   high for the whole break cycle. dev_done is a single-cycle
//                   completion pulse (with dev_err on timeout, dev_rdata valid
//                   for reads). The device must drop dev_req before the next
//                   cpu_slot or it is served again.
//     cpu side    : brk_req asks for a slot; cpu_slot is a one-cycle pulse
//                   offering one; brk_active stalls the CPU for the cycle.
//     memory side : exactly one of ram_rd/ram_wr is held high with ram_addr
//                   (and ram_data_out for writes) stable until ram_done is
//                   seen high; ram_data_in is valid in that same cycle.
interface pdp8_brk_arb_if;
  logic [3:0]  dev_req;
  logic [59:0] dev_addr;
  logic [47:0] dev_wdata;
  logic [3:0]  dev_write;
  logic [3:0]  dev_grant;
  logic [3:0]  dev_done;
  logic        dev_err;
  logic [11:0] dev_rdata;
  logic        cpu_slot;
  logic        brk_req;
  logic        brk_active;
  logic [14:0] ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic [11:0] ram_data_out;
  logic [11:0] ram_data_in;
  logic        ram_done;

  modport slave (
    input  dev_req, dev_addr, dev_wdata, dev_write, cpu_slot,
           ram_data_in, ram_done,
    output dev_grant, dev_done, dev_err, dev_rdata, brk_req, brk_active,
           ram_addr, ram_rd, ram_wr, ram_data_out
  );

  modport master (
    output dev_req, dev_addr, dev_wdata, dev_write, cpu_slot,
           ram_data_in, ram_done,
    input  dev_grant, dev_done, dev_err, dev_rdata, brk_req, brk_active,
           ram_addr, ram_rd, ram_wr, ram_data_out
  );
endinterface

// File: rtl/pdp8_brk_arb.sv
// pdp8_brk_arb
//   PDP-8 data-break (DMA) arbiter for up to four device controllers.
//   Collects break requests, asks the CPU for a slot, grants one device per
//   break cycle (fixed or round-robin priority) and runs that device's
//   single-word transfer against main memory.
//
// Parameters
//   RR      : 0 = fixed priority (device 0 highest), 1 = round-robin starting
//             after the last winner
//   TIMEOUT : XFER cycles to wait for ram_done before aborting (1..63)
// Ports
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : pdp8_brk_arb_if.slave (device, CPU and memory signals)
//   dbg_state : current FSM state (IDLE=0, WAIT_SLOT=1, XFER=2, DONE=3)
module pdp8_brk_arb #(
  parameter bit RR      = 1'b0,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pdp8_brk_arb_if.slave        bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    XFER      = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Last XFER cycle index; the counter starts at 0 on entry so XFER lasts
  // at most TIMEOUT cycles.
  localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  last_winner;
  logic [1:0]  cur_winner;
  logic [5:0]  to_cnt;

  logic [3:0]  grant_q;
  logic [3:0]  done_q;
  logic        err_q;
  logic [11:0] rdata_q;
  logic        brk_req_q;
  logic        active_q;
  logic        rd_q;
  logic        wr_q;
  logic [14:0] addr_q;
  logic [11:0] wdata_q;

  logic        any_req;
  logic [1:0]  search_start;
  logic [7:0]  req_dbl;
  logic [3:0]  req_rot;
  logic [1:0]  rot_off;
  logic [1:0]  winner;
  logic [14:0] sel_addr;
  logic [11:0] sel_wdata;
  logic        sel_write;

  assign any_req = |bus.dev_req;

  // Winner search: rotate the request vector so the search start sits at
  // bit 0, take the lowest set bit, then rotate the index back. For fixed
  // priority the start is always device 0.
  always_comb begin
    search_start = RR ? (last_winner + 2'd1) : 2'd0;
    req_dbl      = {bus.dev_req, bus.dev_req} >> search_start;
    req_rot      = req_dbl[3:0];
    if (req_rot[0])      rot_off = 2'd0;
    else if (req_rot[1]) rot_off = 2'd1;
    else if (req_rot[2]) rot_off = 2'd2;
    else                 rot_off = 2'd3;
    winner       = search_start + rot_off;
  end

  always_comb begin
    sel_addr  = 15'd0;
    sel_wdata = 12'd0;
    sel_write = 1'b0;
    case (winner)
      2'd0: begin
        sel_addr  = bus.dev_addr[14:0];
        sel_wdata = bus.dev_wdata[11:0];
        sel_write = bus.dev_write[0];
      end
      2'd1: begin
        sel_addr  = bus.dev_addr[29:15];
        sel_wdata = bus.dev_wdata[23:12];
        sel_write = bus.dev_write[1];
      end
      2'd2: begin
        sel_addr  = bus.dev_addr[44:30];
        sel_wdata = bus.dev_wdata[35:24];
        sel_write = bus.dev_write[2];
      end
      default: begin
        sel_addr  = bus.dev_addr[59:45];
        sel_wdata = bus.dev_wdata[47:36];
        sel_write = bus.dev_write[3];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_winner <= 2'd3;
      cur_winner  <= 2'd0;
      to_cnt      <= 6'd0;
      grant_q     <= 4'd0;
      done_q      <= 4'd0;
      err_q       <= 1'b0;
      rdata_q     <= 12'd0;
      brk_req_q   <= 1'b0;
      active_q    <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 15'd0;
      wdata_q     <= 12'd0;
    end else begin
      // Completion flags are single-cycle pulses.
      done_q <= 4'd0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= WAIT_SLOT;
            brk_req_q <= 1'b1;
          end
        end
        WAIT_SLOT: begin
          if (bus.cpu_slot) begin
            brk_req_q <= 1'b0;
            if (any_req) begin
              // Device fields are captured here; later changes on the
              // device side cannot disturb the cycle.
              state      <= XFER;
              cur_winner <= winner;
              grant_q    <= 4'b0001 << winner;
              active_q   <= 1'b1;
              addr_q     <= sel_addr;
              wdata_q    <= sel_wdata;
              rd_q       <= ~sel_write;
              wr_q       <= sel_write;
              to_cnt     <= 6'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        XFER: begin
          if (bus.ram_done) begin
            if (rd_q) rdata_q <= bus.ram_data_in;
            done_q <= grant_q;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            state  <= DONE;
          end else if (to_cnt == TO_LAST) begin
            rdata_q <= 12'd0;
            done_q  <= grant_q;
            err_q   <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state   <= DONE;
          end else begin
            to_cnt <= to_cnt + 6'd1;
          end
        end
        DONE: begin
          grant_q     <= 4'd0;
          active_q    <= 1'b0;
          last_winner <= cur_winner;
          if (any_req) begin
            state     <= WAIT_SLOT;
            brk_req_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dev_grant    = grant_q;
  assign bus.dev_done     = done_q;
  assign bus.dev_err      = err_q;
  assign bus.dev_rdata    = rdata_q;
  assign bus.brk_req      = brk_req_q;
  assign bus.brk_active   = active_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_rd       = rd_q;
  assign bus.ram_wr       = wr_q;
  assign bus.ram_data_out = wdata_q;
  assign dbg_state        = state;

endmodule
